timer_scheduler: RTL

//   Shares one 16-bit countdown engine between NUM_REQ requesters. Round-robin arbitration

---
 rtl/timer_scheduler.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/timer_scheduler.sv
// Shared 16-bit countdown engine with round-robin arbitration between NUM_REQ requesters.
// Only req_ready is combinational; every other output comes straight from a flop.
module timer_scheduler #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*CNT_W-1:0]   req_val,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ-1:0]         abort,
   input  logic                       irq_clr,
   output logic [NUM_REQ-1:0]         done,
   output logic                       irq,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic [CNT_W-1:0]           count
);

   localparam int unsigned OW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

   state_e             state_q, state_d;
   logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [OW-1:0]      owner_q, owner_d;
   logic [15:0]        psc_q, psc_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               irq_q, irq_d;
   logic               busy_q, busy_d;

   logic [OW-1:0]      grant_idx, cand_idx, next_ptr;
   logic [CNT_W-1:0]   load_val;
   logic               grant_any, tick;
   int unsigned        cand;

   // First valid requester at or above rr_ptr, wrapping around.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = cand[OW-1:0];
         if (!grant_any && req_valid[cand_idx]) begin
            grant_any = 1'b1;
            grant_idx = cand_idx;
         end
      end
   end

   // A zero load would never expire, so it is promoted to one tick.
   always_comb begin
      load_val = req_val[int'(grant_idx)*CNT_W +: CNT_W];
      if (load_val == '0) load_val = CNT_W'(1);
   end

   assign tick     = (psc_q == 16'(PRESCALE - 1));
   assign next_ptr = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      psc_d     = psc_q;
      count_d   = count_q;
      busy_d    = busy_q;
      done_d    = '0;
      req_ready = '0;
      irq_d     = irq_clr ? 1'b0 : irq_q;

      unique case (state_q)
         StIdle: begin
            if (grant_any) begin
               req_ready[grant_idx] = 1'b1;
               owner_d              = grant_idx;
               count_d              = load_val;
               psc_d                = '0;
               busy_d               = 1'b1;
               state_d              = StCount;
            end
         end
         StCount: begin
            // Abort beats a coinciding final tick: the job is dropped silently.
            if (abort[owner_q]) begin
               state_d  = StIdle;
               busy_d   = 1'b0;
               count_d  = '0;
               psc_d    = '0;
               rr_ptr_d = next_ptr;
            end else begin
               psc_d = tick ? '0 : psc_q + 16'd1;
               if (tick && count_q != '0) begin
                  count_d = count_q - CNT_W'(1);
                  if (count_q == CNT_W'(1)) begin
                     state_d         = StDone;
                     done_d[owner_q] = 1'b1;
                  end
               end
            end
         end
         StDone: begin
            irq_d    = 1'b1;
            rr_ptr_d = next_ptr;
            busy_d   = 1'b0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (reset) req_ready = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         psc_q    <= '0;
         count_q  <= '0;
         done_q   <= '0;
         irq_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         psc_q    <= psc_d;
         count_q  <= count_d;
         done_q   <= done_d;
         irq_q    <= irq_d;
         busy_q   <= busy_d;
      end
   end

   assign done  = done_q;
   assign irq   = irq_q;
   assign busy  = busy_q;
   assign owner = owner_q;
   assign count = count_q;

endmodule
